xt_hb_arbiter: RTL

- Shares the single XT_HB high-speed bus between NUM_MASTERS requesters (e.g. instruction fetch, data port, DMA).
- Selects one master per cycle by round-robin and drives its request onto the shared hb_slave_t bus plus read/write strobes.
- Routes the 1-cycle-latency read data back to the granted master.
- Supports a bounded bus lock so a master can run back-to-back accesses uninterrupted.

---
 rtl/xt_hb_arbiter_if.sv | 73 +++++++
 rtl/xt_hb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/xt_hb_arbiter_if.sv
// -----------------------------------------------------------------------------
// xt_hb_pkg / xt_hb_arbiter_if
//
// Purpose: shared types for the XT_HB high-speed bus, plus the interface that
// bundles every master-side and slave-side signal of the arbiter.
//
// Handshake: a master's request is valid while m_in[i].read | m_in[i].write is
// high. m_ack[i] is the accept. The request is taken on a cycle where both are
// high. The master holds its request stable until it sees m_ack[i], and may
// change or drop it on the following cycle. There is no back-pressure on read
// data: m_rvalid[i] marks hb_rdata_out for master i for exactly one cycle.
//
// Signals (interface xt_hb_arbiter_if):
//   m_in[N]       per-master request (read, write, write_width, raddr, waddr, wdata)
//   m_lock[N]     master wants to keep ownership after the current grant
//   m_ack[N]      one-hot request accepted this cycle
//   m_rvalid[N]   one-hot owner of hb_rdata_out this cycle
//   hb_rdata_out  read data broadcast to masters
//   hb_out        shared slave bus (raddr, waddr, wdata, write_width)
//   hb_read       read strobe to slaves
//   hb_write      write strobe to slaves
//   hb_rdata      slave read data, valid one cycle after hb_read
// Modports: slave  = the arbiter's view
//           master = the surrounding system's view (masters + slaves)
// -----------------------------------------------------------------------------
package xt_hb_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [1:0]  write_width;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } hb_master_in_t;

    typedef struct packed {
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  write_width;
    } hb_slave_t;

    typedef enum logic {
        ARB   = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

endpackage

interface xt_hb_arbiter_if #(
    parameter int NUM_MASTERS = 3
);
    xt_hb_pkg::hb_master_in_t [NUM_MASTERS-1:0] m_in;
    logic [NUM_MASTERS-1:0]                     m_lock;
    logic [NUM_MASTERS-1:0]                     m_ack;
    logic [NUM_MASTERS-1:0]                     m_rvalid;
    logic [31:0]                                hb_rdata_out;
    xt_hb_pkg::hb_slave_t                       hb_out;
    logic                                       hb_read;
    logic                                       hb_write;
    logic [31:0]                                hb_rdata;

    modport slave (
        input  m_in, m_lock, hb_rdata,
        output m_ack, m_rvalid, hb_rdata_out, hb_out, hb_read, hb_write
    );

    modport master (
        output m_in, m_lock, hb_rdata,
        input  m_ack, m_rvalid, hb_rdata_out, hb_out, hb_read, hb_write
    );
endinterface

// File: rtl/xt_hb_arbiter.sv
// -----------------------------------------------------------------------------
// xt_hb_arbiter
//
// Purpose: shares the single XT_HB bus between NUM_MASTERS requesters. One
// master is granted per cycle, combinationally in the request cycle, chosen by
// round-robin. A master may lock the bus for up to LOCK_MAX consecutive
// grants. Read data (1-cycle slave latency) is tagged back to the master that
// issued the read.
//
// Parameters:
//   NUM_MASTERS  number of requesters (2..8)
//   LOCK_MAX     max consecutive grants of one locked owner (1..255)
//
// Ports:
//   clk          bus clock
//   rst_n        synchronous reset, active-low
//   bus          xt_hb_arbiter_if.slave (all master and slave bus signals)
//   dbg_state_o  current arbitration state (ARB / OWNED)
//
// Build option: define XT_HB_ARB_PRIO_EN to give master 0 fixed top priority
// in ARB (masters 1..N-1 round-robin among themselves). A pending master-0
// request also ends any lock held by another master right after that owner's
// current grant.
// -----------------------------------------------------------------------------
module xt_hb_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int LOCK_MAX    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xt_hb_arbiter_if.slave        bus,
    output xt_hb_pkg::arb_state_e dbg_state_o
);
    import xt_hb_pkg::*;

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    typedef logic [PW-1:0] idx_t;

`ifdef XT_HB_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    // Next index in search order, wrapping at NUM_MASTERS.
    function automatic idx_t inc_idx(input idx_t i);
        if (int'(i) == NUM_MASTERS - 1) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

    arb_state_e             state_q, state_d;
    idx_t                   rr_ptr_q, rr_ptr_d;
    idx_t                   owner_q, owner_d;
    logic [7:0]             lock_cnt_q, lock_cnt_d;
    logic                   relock_blk_q, relock_blk_d;
    logic [NUM_MASTERS-1:0] rd_owner_q, rd_owner_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic                   others_req;
    logic                   rr_vld;
    idx_t                   rr_win;
    idx_t                   srch_idx;
    logic                   grant_vld;
    idx_t                   winner;
    logic [8:0]             cnt_nxt;
    logic                   prio_preempt;
    logic [NUM_MASTERS-1:0] ack;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i] = bus.m_in[i].read | bus.m_in[i].write;
        end
    end

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
    end

    assign others_req   = |(req & ~owner_mask);
    assign cnt_nxt      = {1'b0, lock_cnt_q} + 9'd1;
    assign prio_preempt = PRIO_EN && req[0] && (owner_q != '0);

    // Round-robin search starting at rr_ptr. With priority enabled master 0
    // is handled separately, so it is skipped here.
    always_comb begin
        rr_vld   = 1'b0;
        rr_win   = '0;
        srch_idx = rr_ptr_q;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!rr_vld && req[srch_idx] && !(PRIO_EN && srch_idx == '0)) begin
                rr_vld = 1'b1;
                rr_win = srch_idx;
            end
            srch_idx = inc_idx(srch_idx);
        end
    end

    // Arbitration FSM: next state and grant selection.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        relock_blk_d = relock_blk_q;
        grant_vld    = 1'b0;
        winner       = '0;

        // The re-lock block lasts until nobody else is competing.
        if (!others_req) begin
            relock_blk_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (PRIO_EN && req[0]) begin
                    grant_vld = 1'b1;
                    winner    = '0;
                end else if (rr_vld) begin
                    grant_vld = 1'b1;
                    winner    = rr_win;
                end
                if (grant_vld) begin
                    rr_ptr_d = inc_idx(winner);
                    if (winner != owner_q) begin
                        relock_blk_d = 1'b0;
                    end
                    // A master that just hit the lock cap may not re-lock
                    // while others are waiting.
                    if (bus.m_lock[winner] &&
                        !(relock_blk_q && winner == owner_q && others_req)) begin
                        owner_d = winner;
                        if (LOCK_MAX > 1) begin
                            state_d    = OWNED;
                            lock_cnt_d = 8'd1;
                        end else begin
                            // One grant already exhausts the lock budget.
                            relock_blk_d = 1'b1;
                        end
                    end
                end
            end

            OWNED: begin
                if (req[owner_q]) begin
                    grant_vld = 1'b1;
                    winner    = owner_q;
                    // lock_cnt counts grants already given; this grant is
                    // number cnt_nxt, and the owner keeps the bus only if
                    // another one is still allowed afterwards.
                    if (bus.m_lock[owner_q] && (cnt_nxt < 9'(LOCK_MAX)) && !prio_preempt) begin
                        lock_cnt_d = cnt_nxt[7:0];
                    end else begin
                        state_d      = ARB;
                        rr_ptr_d     = inc_idx(owner_q);
                        lock_cnt_d   = '0;
                        relock_blk_d = bus.m_lock[owner_q];
                    end
                end else if (!bus.m_lock[owner_q]) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end
            end

            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Bus drive: the winner's fields, or all zeros when nothing is granted.
    always_comb begin
        ack          = '0;
        bus.hb_out   = '0;
        bus.hb_read  = 1'b0;
        bus.hb_write = 1'b0;
        if (grant_vld) begin
            ack[winner]            = 1'b1;
            bus.hb_out.raddr       = bus.m_in[winner].raddr;
            bus.hb_out.waddr       = bus.m_in[winner].waddr;
            bus.hb_out.wdata       = bus.m_in[winner].wdata;
            bus.hb_out.write_width = bus.m_in[winner].write_width;
            bus.hb_read            = bus.m_in[winner].read;
            bus.hb_write           = bus.m_in[winner].write;
        end
    end

    assign rd_owner_d       = bus.hb_read ? ack : '0;
    assign bus.m_ack        = ack;
    assign bus.m_rvalid     = rd_owner_q;
    assign bus.hb_rdata_out = bus.hb_rdata;
    assign dbg_state_o      = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            relock_blk_q <= 1'b0;
            rd_owner_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule
